// File: rtl/aes_word_sequencer_if.sv
// Bundle between the AES word sequencer and its neighbours: key-word writes, the 32-bit input
// and output word streams, the core-side control/data, and a debug view of the sequencer state.
//
// Handshake semantics: a word moves on a rising clk edge where valid & ready are both high.
// The producer holds valid and data stable until that edge. ready may change freely when valid
// is low. key_wr has no hold requirement: a write on a cycle without key_ready is simply dropped.
interface aes_word_sequencer_if;
  logic         key_wr;
  logic [2:0]   key_idx;
  logic [31:0]  key_word;
  logic         key_ready;

  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_enc_dec;
  logic [1:0]   in_mode;

  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         err;

  logic         core_start;
  logic         core_enc_dec;
  logic [1:0]   core_mode;
  logic [255:0] core_key;
  logic [127:0] core_data_in;
  logic [127:0] core_data_out;
  logic         core_done;

  logic [1:0]   dbg_state;

  modport master (
    output key_wr, key_idx, key_word, in_valid, in_data, in_enc_dec, in_mode,
           out_ready, core_data_out, core_done,
    input  key_ready, in_ready, out_valid, out_data, err, core_start, core_enc_dec,
           core_mode, core_key, core_data_in, dbg_state
  );

  modport slave (
    input  key_wr, key_idx, key_word, in_valid, in_data, in_enc_dec, in_mode,
           out_ready, core_data_out, core_done,
    output key_ready, in_ready, out_valid, out_data, err, core_start, core_enc_dec,
           core_mode, core_key, core_data_in, dbg_state
  );
endinterface

// File: rtl/aes_word_sequencer.sv
// Word-stream adapter for an AES core: packs four input words into a block, holds a 256-bit key,
// starts the core, waits for done (with timeout) and streams the result out MSW first.
module aes_word_sequencer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               reset,
  aes_word_sequencer_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [1:0]     wcnt;
  logic [1:0]     rcnt;
  logic [TW-1:0]  timer;
  logic [255:0]   key_q;
  logic [127:0]   blk_q;
  logic [127:0]   out_buf;
  logic           enc_dec_q;
  logic [1:0]     mode_q;
  logic           err_q;

  logic in_ready_c, out_valid_c, key_ready_c, start_c, timeout_c;
  logic in_fire, out_fire, key_fire;

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    key_ready_c = 1'b0;
    start_c     = 1'b0;
    timeout_c   = 1'b0;
    case (state)
      S_FILL: begin
        in_ready_c  = 1'b1;
        key_ready_c = (wcnt == 2'd0);
        if (bus.in_valid && wcnt == 2'd3) state_nxt = S_START;
      end
      S_START: begin
        start_c   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last timer cycle still counts as success.
        if (bus.core_done) begin
          state_nxt = S_DRAIN;
        end else if (timer == TIMER_LAST) begin
          timeout_c = 1'b1;
          state_nxt = S_FILL;
        end
      end
      S_DRAIN: begin
        out_valid_c = 1'b1;
        if (bus.out_ready && rcnt == 2'd3) state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  assign in_fire  = in_ready_c & bus.in_valid;
  assign out_fire = out_valid_c & bus.out_ready;
  assign key_fire = key_ready_c & bus.key_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FILL;
      wcnt      <= 2'd0;
      rcnt      <= 2'd0;
      timer     <= '0;
      key_q     <= '0;
      blk_q     <= '0;
      out_buf   <= '0;
      enc_dec_q <= 1'b0;
      mode_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      // Slot n of the block sits at bits [127-32n -: 32]; ~n*32 gives its low bit.
      if (in_fire) begin
        blk_q[{~wcnt, 5'b0} +: 32] <= bus.in_data;
        wcnt <= wcnt + 2'd1;
        if (wcnt == 2'd0) begin
          enc_dec_q <= bus.in_enc_dec;
          mode_q    <= bus.in_mode;
        end
      end
      if (key_fire) key_q[{~bus.key_idx, 5'b0} +: 32] <= bus.key_word;
      if (state == S_START) timer <= '0;
      else if (state == S_WAIT) timer <= timer + TW'(1);
      if (state == S_WAIT && bus.core_done) out_buf <= bus.core_data_out;
      if (timeout_c) err_q <= 1'b1;
      if (out_fire) rcnt <= rcnt + 2'd1;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.key_ready    = key_ready_c;
  assign bus.core_start   = start_c;
  assign bus.out_data     = out_buf[{~rcnt, 5'b0} +: 32];
  assign bus.err          = err_q;
  assign bus.core_key     = key_q;
  assign bus.core_data_in = blk_q;
  assign bus.core_mode    = mode_q;
  assign bus.core_enc_dec = enc_dec_q;
  assign bus.dbg_state    = state;

endmodule
